// File: rtl/shift_right_seq_if.sv
// ============================================================================
// shift_right_seq_if : start/busy/done handshake bundle for shift_right_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

interface shift_right_seq_if #(
  parameter int SIZE    = 32,
  parameter int SHAMT_W = 5
);
  logic               start;
  logic [SIZE-1:0]    a;
  logic [SHAMT_W-1:0] shamt;
  logic               arith;
  logic               busy;
  logic               done;
  logic [SIZE-1:0]    out;

  modport master (
    output start, a, shamt, arith,
    input  busy, done, out
  );

  modport slave (
    input  start, a, shamt, arith,
    output busy, done, out
  );
endinterface

`default_nettype wire

// File: rtl/shift_right_seq.sv
// ============================================================================
// shift_right_seq : multi-cycle logical/arithmetic right shifter, STEP bits/clk
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_right_seq #(
  parameter int SIZE    = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 4
) (
  input  wire               clk,
  input  wire               rst_n,
  shift_right_seq_if.slave  bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  // One bit wider than cnt so STEP == 2^SHAMT_W stays representable.
  localparam logic [SHAMT_W:0] c_STEP = (SHAMT_W + 1)'(STEP);

  logic [1:0]         state_q, state_d;
  logic [SIZE-1:0]    wr_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               fill_q;
  logic [SIZE-1:0]    out_q;
  logic               busy_d, done_d;

  logic [SHAMT_W-1:0] w_k;
  logic [SHAMT_W-1:0] w_cnt_next;
  logic [SIZE-1:0]    w_fill_mask;
  logic [SIZE-1:0]    w_wr_shifted;

  // k never exceeds cnt, so the final partial step lands exactly on zero.
  assign w_k          = ({1'b0, cnt_q} < c_STEP) ? cnt_q : c_STEP[SHAMT_W-1:0];
  assign w_cnt_next   = cnt_q - w_k;
  assign w_fill_mask  = ~({SIZE{1'b1}} >> w_k);
  assign w_wr_shifted = (wr_q >> w_k) | (fill_q ? w_fill_mask : {SIZE{1'b0}});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE:  if (bus.start) state_d = (bus.shamt == '0) ? c_DONE : c_SHIFT;
      c_SHIFT: if (w_cnt_next == '0) state_d = c_DONE;
      c_DONE:  state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_q == c_SHIFT) || (state_q == c_DONE);
    done_d = (state_q == c_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q   <= '0;
      cnt_q  <= '0;
      fill_q <= 1'b0;
      out_q  <= '0;
    end else begin
      case (state_q)
        c_IDLE: begin
          if (bus.start) begin
            wr_q   <= bus.a;
            cnt_q  <= bus.shamt;
            fill_q <= bus.arith & bus.a[SIZE-1];
            if (bus.shamt == '0) out_q <= bus.a;
          end
        end
        c_SHIFT: begin
          wr_q  <= w_wr_shifted;
          cnt_q <= w_cnt_next;
          if (w_cnt_next == '0) out_q <= w_wr_shifted;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_d;
  assign bus.done = done_d;
  assign bus.out  = out_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_right_seq.sv
// ============================================================================
// tb_shift_right_seq : vector table, corner sequences and random ops vs model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_shift_right_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [31:0] model_out;

  shift_right_seq_if #(.SIZE(32), .SHAMT_W(5)) bus ();

  shift_right_seq #(.SIZE(32), .SHAMT_W(5), .STEP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] exp_out;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Behavioural reference: plain shift operators, latency from ceil division.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh, input logic ar);
    logic signed [31:0] sa;
    sa = a;
    return ar ? 32'(sa >>> sh) : (a >> sh);
  endfunction

  task automatic run_op(input logic [31:0] a_v, input logic [4:0] sh, input logic ar,
                        input logic [31:0] exp_out, input int exp_lat, input string tag);
    int   n;
    logic held;
    logic busy_ok;
    bus.start = 1'b1;
    bus.a     = a_v;
    bus.shamt = sh;
    bus.arith = ar;
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.shamt = 5'($urandom);
    bus.arith = 1'($urandom);
    n = 0;
    held = 1'b1;
    busy_ok = 1'b1;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      if (bus.out !== model_out) held = 1'b0;
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " out"}, bus.out, exp_out);
    chk({tag, " busy_at_done"}, {31'b0, bus.busy}, 32'd1);
    chk({tag, " busy_in_flight"}, {31'b0, busy_ok}, 32'd1);
    chk({tag, " out_held"}, {31'b0, held}, 32'd1);
    model_out = exp_out;
    tick();
    chk({tag, " idle_after_done"}, {30'b0, bus.busy, bus.done}, 32'd0);
    chk({tag, " out_hold_idle"}, bus.out, model_out);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    model_out = '0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 32'hA5A5A5A5;
    bus.shamt = 5'd3;
    bus.arith = 1'b0;

    vecs[0] = '{32'h80000000, 5'd31, 1'b0, 32'h00000001, 8};
    vecs[1] = '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF, 8};
    vecs[2] = '{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000, 8};
    vecs[3] = '{32'hDEADBEEF, 5'd0,  1'b0, 32'hDEADBEEF, 0};
    vecs[4] = '{32'hF0000000, 5'd8,  1'b1, 32'hFFF00000, 2};
    vecs[5] = '{32'h12345678, 5'd4,  1'b0, 32'h01234567, 1};
    vecs[6] = '{32'h00000100, 5'd5,  1'b0, 32'h00000008, 2};
    vecs[7] = '{32'h80000000, 5'd3,  1'b1, 32'hF0000000, 1};
    vecs[8] = '{32'h87654321, 5'd5,  1'b1, 32'hFC3B2A19, 2};

    // Reset held with start asserted: reset must win.
    tick();
    tick();
    chk("reset busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
    chk("reset out", bus.out, 32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle after reset", {30'b0, bus.busy, bus.done}, 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].shamt, vecs[i].arith, vecs[i].exp_out, vecs[i].exp_lat,
             $sformatf("vec%0d", i));
    end

    // start while busy, including during the DONE cycle, is ignored.
    bus.start = 1'b1; bus.a = 32'hF0000000; bus.shamt = 5'd8; bus.arith = 1'b1;
    tick();
    bus.a = 32'h0000FFFF; bus.shamt = 5'd1; bus.arith = 1'b0;
    tick();
    chk("busy E1 done", {30'b0, bus.busy, bus.done}, 32'd2);
    tick();
    chk("busy E2 done", {30'b0, bus.busy, bus.done}, 32'd3);
    chk("busy E2 out", bus.out, 32'hFFF00000);
    tick();
    bus.start = 1'b0;
    chk("ignored start idle", {30'b0, bus.busy, bus.done}, 32'd0);
    tick();
    tick();
    chk("ignored start state", {30'b0, bus.busy, bus.done}, 32'd0);
    chk("ignored start out", bus.out, 32'hFFF00000);
    model_out = 32'hFFF00000;

    // Reset mid-operation aborts without writing out.
    bus.start = 1'b1; bus.a = 32'hFFFF0000; bus.shamt = 5'd20; bus.arith = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort busy_done", {30'b0, bus.busy, bus.done}, 32'd0);
    chk("abort out", bus.out, 32'd0);
    model_out = '0;
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (bus.done !== 1'b0 || bus.out !== 32'd0) seen = 1'b1;
        tick();
      end
      chk("abort no done", {31'b0, seen}, 32'd0);
    end
    run_op(32'h12345678, 5'd4, 1'b0, 32'h01234567, 1, "post_abort");
    // run_op returns in the idle cycle right after done: back-to-back start.
    run_op(32'h00000100, 5'd5, 1'b0, 32'h00000008, 2, "back2back");

    for (int r = 0; r < 150; r++) begin
      logic [31:0] ra;
      logic [4:0]  rs;
      logic        rar;
      ra  = $urandom;
      rs  = 5'($urandom);
      rar = 1'($urandom);
      if (r % 5 == 0) ra[31] = 1'b1;
      run_op(ra, rs, rar, ref_shift(ra, rs, rar), (int'(rs) + 3) / 4, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Multi-cycle right shifter for the MIPS_32 datapath; the right-direction companion to the combinational left shifter.
- Executes SRL/SRA/SRLV/SRAV-class operations, shifting at most STEP bit positions per clock.
- Uses a start/busy/done handshake, so the control unit stalls on busy.
- Trades latency for area against a full barrel shifter.

Parameters:
- SIZE, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; SIZE must be at most 2^SHAMT_W.
- STEP, 4, maximum bit positions shifted per clock; legal range 1 to SIZE.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  SIZE  operand, captured when start is accepted.
- shamt  input  SHAMT_W  shift amount, captured when start is accepted.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); captured when start is accepted.
- busy  output  1  high while an operation is in flight, including the DONE cycle.
- done  output  1  one-cycle pulse; out is valid from this cycle onward.
- out  output  SIZE  result register.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset: when rst_n=0 at a rising edge, the block goes to IDLE with busy=0, done=0 and out=0.
  - Reset overrides start.
  - Reset aborts any operation in flight; no partial result is ever written to out.
- Internal state: working register wr (SIZE bits), remaining count cnt (SHAMT_W bits), fill bit.
- State machine has three states: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - Load wr=a, cnt=shamt, fill=arith & a[SIZE-1].
  - Next state is DONE if shamt=0, otherwise SHIFT.
- IDLE, start=0: stay in IDLE.
- SHIFT, each edge:
  - k = min(cnt, STEP).
  - wr becomes wr shifted right by k, with k copies of fill entering at the MSB.
  - cnt becomes cnt-k.
  - If the new cnt is 0, load out with the new wr value and go to DONE; otherwise stay in SHIFT.
- shamt=0 path: out is loaded with a at the E0 edge.
- DONE: done=1 for exactly one cycle; next edge returns to IDLE.
- Outputs:
  - busy=1 in SHIFT and DONE; busy=0 in IDLE.
  - done=1 only in DONE.
- Latency: done is high in the cycle following edge E0+ceil(shamt/STEP).
  - shamt=0: done in the cycle after E0.
  - shamt=31, STEP=4: done in the cycle after E8.
- start while busy=1 is ignored, including during the DONE cycle; it is not queued.
- The earliest next accepted start is the cycle after done.
- out changes only on the transition into DONE, or on reset. It holds its value through IDLE and through the next operation until that operation's result is loaded.
- Inputs a, shamt and arith are don't-care after acceptance.
- Arithmetic:
  - No shift amount outside 0 to 2^SHAMT_W-1 exists.
  - If shamt is at least SIZE, the result is all fill bits.
  - The per-step k never exceeds cnt, so the final partial step is exact.
- Logical shift of a negative operand zero-fills.
- Arithmetic shift of a non-negative operand zero-fills.

Test Plan:
- Logical shift:
  - Stimulus: SIZE=32, STEP=4; a=0x80000000, shamt=31, arith=0; start at E0.
  - Response: out=0x00000001; done is high only in the cycle after E8; busy high from after E0 through the done cycle.
- Arithmetic shift:
  - Stimulus: same as above with arith=1.
  - Response: out=0xFFFFFFFF.
  - Stimulus: a=0x7FFFFFFF, shamt=31, arith=1.
  - Response: out=0x00000000.
- Zero shift:
  - Stimulus: a=0xDEADBEEF, shamt=0.
  - Response: out=0xDEADBEEF; done in the cycle after E0; exactly one done pulse.
- start while busy:
  - Stimulus: a=0xF0000000, shamt=8, arith=1 at E0; then start with a=0x0000FFFF, shamt=1 asserted at E1 and during the DONE cycle.
  - Response: out=0xFFF00000, done after E2; both extra starts are ignored and out remains 0xFFF00000.
- Reset mid-operation:
  - Stimulus: a=0xFFFF0000, shamt=20, arith=0; rst_n=0 at E3.
  - Response: the next cycle shows busy=0, done=0, out=0, and no done pulse ever appears.
  - Stimulus: then a=0x12345678, shamt=4, arith=0.
  - Response: out=0x01234567, done after 1 shift edge.
- Back-to-back operations:
  - Stimulus: start in the cycle immediately after done with a=0x00000100, shamt=5, arith=0.
  - Response: out=0x00000008 after 2 shift edges; the previous out is held until then.
